// File: rtl/tempo_pkg.sv
// Shared types and helpers for the tempo control slice: widths, divider
// state encoding and binary-to-BCD conversion for the seven-segment digits.
package tempo_pkg;

    localparam int BPM_W    = 8;
    localparam int PERIOD_W = 32;
    localparam int BCD_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [BCD_W-1:0] hund;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } bcd3_t;

    // Split an 8-bit tempo into hundreds/tens/units digits.
    function automatic bcd3_t bin8_to_bcd(input logic [BPM_W-1:0] b);
        bcd3_t            r;
        logic [BPM_W-1:0] rest;
        r.hund  = BCD_W'(b / 8'd100);
        rest    = b % 8'd100;
        r.tens  = BCD_W'(rest / 8'd10);
        r.units = BCD_W'(rest % 8'd10);
        return r;
    endfunction

endpackage

// File: rtl/tempo_ctrl_key_debounce.sv
// One raw push-button: 2-FF synchronizer, stable-level debounce counter and a
// single-cycle press pulse on the released->pressed (1->0) transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    // Synchronize, then accept a level change only after it has been stable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b1;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync2;
                count <= '0;
                press <= ~sync2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tempo_ctrl.sv
// Tempo owner for the metronome: debounced tap keys and switch presets set
// bpm, the BCD digits follow bpm, and a 32-step restoring divider turns bpm
// into a beat period in clock cycles.
//
// Output handshake: period_valid is a one-cycle strobe qualifying
// beat_period; there is no ready, the consumer samples beat_period on the
// strobe. beat_period only changes on the strobe cycle and is otherwise
// stable, so a partially computed quotient is never visible.
module tempo_ctrl
    import tempo_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BPM_MIN         = 60,
    parameter int BPM_MAX         = 230,
    parameter int BPM_STEP        = 10,
    parameter int BPM_DEFAULT     = 120
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tapup_n,
    input  logic                tapdown_n,
    input  logic [4:0]          sw_preset,
    output logic [BPM_W-1:0]    bpm,
    output logic [BCD_W-1:0]    hex100,
    output logic [BCD_W-1:0]    hex10,
    output logic [BCD_W-1:0]    hex0,
    output logic [PERIOD_W-1:0] beat_period,
    output logic                period_valid,
    output logic                busy
);

    localparam logic [63:0]         DIVIDEND_W   = 64'(CLK_HZ) * 64'd60;
    localparam logic [PERIOD_W-1:0] DIVIDEND     = DIVIDEND_W[PERIOD_W-1:0];
    localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(DIVIDEND_W / 64'(BPM_DEFAULT));
    localparam logic [BPM_W-1:0]    BMIN         = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0]    BMAX         = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0]    BSTEP        = BPM_W'(BPM_STEP);
    localparam logic [BPM_W-1:0]    BDEF         = BPM_W'(BPM_DEFAULT);
    localparam bcd3_t               DEFAULT_BCD  = bin8_to_bcd(BDEF);

    // ---------------- input conditioning ----------------
    logic       up_press;
    logic       dn_press;
    logic [4:0] sw_s1;
    logic [4:0] sw_s2;
    logic [4:0] sw_last;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clock (clock),
        .reset (reset),
        .key_n (tapup_n),
        .press (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
        .clock (clock),
        .reset (reset),
        .key_n (tapdown_n),
        .press (dn_press)
    );

    // ---------------- tempo update ----------------
    logic [15:0]      preset_sum;
    logic [BPM_W-1:0] preset_val;
    logic [BPM_W:0]   up_sum;
    logic [BPM_W-1:0] up_val;
    logic [BPM_W-1:0] dn_val;
    logic [BPM_W-1:0] bpm_next;
    logic             bpm_update;
    bcd3_t            digits_next;

    // Next tempo: a switch change wins, then a lone key press, saturating.
    always_comb begin
        preset_sum = 16'(BPM_MIN) + 16'(BPM_STEP) * {11'd0, sw_s2};
        preset_val = (preset_sum > 16'(BPM_MAX)) ? BMAX : preset_sum[BPM_W-1:0];
        up_sum     = {1'b0, bpm} + {1'b0, BSTEP};
        up_val     = (up_sum > {1'b0, BMAX}) ? BMAX : up_sum[BPM_W-1:0];
        dn_val     = ({1'b0, bpm} < ({1'b0, BMIN} + {1'b0, BSTEP})) ? BMIN : (bpm - BSTEP);
        bpm_next   = bpm;
        if (sw_s2 != sw_last) begin
            bpm_next = preset_val;
        end else if (up_press && !dn_press) begin
            bpm_next = up_val;
        end else if (dn_press && !up_press) begin
            bpm_next = dn_val;
        end
        bpm_update  = (bpm_next != bpm);
        digits_next = bin8_to_bcd(bpm_next);
    end

    // Tempo, display digits and switch synchronizer registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_last <= '0;
            bpm     <= BDEF;
            hex100  <= DEFAULT_BCD.hund;
            hex10   <= DEFAULT_BCD.tens;
            hex0    <= DEFAULT_BCD.units;
        end else begin
            sw_s1   <= sw_preset;
            sw_s2   <= sw_s1;
            sw_last <= sw_s2;
            bpm     <= bpm_next;
            hex100  <= digits_next.hund;
            hex10   <= digits_next.tens;
            hex0    <= digits_next.units;
        end
    end

    // ---------------- beat period divider ----------------
    div_state_t          state;
    logic                bpm_changed;
    logic [BPM_W-1:0]    divisor;
    logic [PERIOD_W-1:0] quot;
    logic [BPM_W-1:0]    rem;
    logic [4:0]          bit_cnt;
    logic [BPM_W:0]      rem_shift;
    logic                rem_fits;
    logic [BPM_W-1:0]    rem_next;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem, quot[PERIOD_W-1]};
        rem_fits  = (rem_shift >= {1'b0, divisor});
        rem_next  = rem_fits ? (rem_shift[BPM_W-1:0] - divisor) : rem_shift[BPM_W-1:0];
    end

    // Divider FSM: latch bpm on IDLE exit, 32 quotient bits, publish in DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            bpm_changed  <= 1'b0;
            divisor      <= '0;
            quot         <= '0;
            rem          <= '0;
            bit_cnt      <= '0;
            beat_period  <= RESET_PERIOD;
            period_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bpm_changed) begin
                        divisor <= bpm;
                        quot    <= DIVIDEND;
                        rem     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    quot    <= {quot[PERIOD_W-2:0], rem_fits};
                    rem     <= rem_next;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    beat_period  <= quot;
                    period_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A tempo change on the very edge that starts a division must not be lost.
            if (bpm_update) begin
                bpm_changed <= 1'b1;
            end else if (state == IDLE && bpm_changed) begin
                bpm_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tempo_ctrl.sv
// Bench for tempo_ctrl: directed key/switch/reset stimulus, a tempo
// scoreboard fed by the stimulus, and a per-cycle model of the divider
// timing and results derived from the tempo sequence.
module tb_tempo_ctrl;

  localparam longint DIVIDEND     = 64'd3000000000;
  localparam longint RESET_PERIOD = 64'd25000000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tapup_n = 1'b1;
  logic        tapdown_n = 1'b1;
  logic [4:0]  sw_preset = 5'd0;
  logic [7:0]  bpm;
  logic [3:0]  hex100;
  logic [3:0]  hex10;
  logic [3:0]  hex0;
  logic [31:0] beat_period;
  logic        period_valid;
  logic        busy;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  logic rst_q = 1'b0;
  always @(posedge clock) rst_q <= reset;

  tempo_ctrl #(
    .CLK_HZ          (50000000),
    .DEBOUNCE_CYCLES (4),
    .BPM_MIN         (60),
    .BPM_MAX         (230),
    .BPM_STEP        (10),
    .BPM_DEFAULT     (120)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tapup_n      (tapup_n),
    .tapdown_n    (tapdown_n),
    .sw_preset    (sw_preset),
    .bpm          (bpm),
    .hex100       (hex100),
    .hex10        (hex10),
    .hex0         (hex0),
    .beat_period  (beat_period),
    .period_valid (period_valid),
    .busy         (busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  function automatic void check(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  int     cur_bpm     = 120;
  bit     pending     = 1'b0;
  bit     running     = 1'b0;
  int     start_n     = 0;
  int     run_bpm     = 120;
  int     n           = 0;
  longint exp_period  = RESET_PERIOD;

  // Every cycle: tempo follows the expected sequence, divider result arrives
  // 33 cycles after the division starts, starts only when idle and a change is pending.
  always @(negedge clock) begin
    bit exp_valid;
    bit exp_busy;
    n = n + 1;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    if (!rst_q) begin
      running    = 1'b0;
      pending    = 1'b0;
      cur_bpm    = 120;
      exp_period = RESET_PERIOD;
      exp_q.delete();
    end else begin
      if (pending && !running) begin
        running = 1'b1;
        start_n = n;
        run_bpm = cur_bpm;
        pending = 1'b0;
      end
      if (exp_q.size() > 0 && bpm == exp_q[0]) begin
        cur_bpm = int'(exp_q.pop_front());
        pending = 1'b1;
      end
      exp_valid = running && (n == start_n + 33);
      exp_busy  = running && (n < start_n + 33);
      if (exp_valid) begin
        exp_period = DIVIDEND / run_bpm;
        running    = 1'b0;
      end
    end
    check("bpm", bpm, cur_bpm);
    check("hex100", hex100, cur_bpm / 100);
    check("hex10", hex10, (cur_bpm / 10) % 10);
    check("hex0", hex0, cur_bpm % 10);
    check("period_valid", period_valid, exp_valid);
    check("busy", busy, exp_busy);
    check("beat_period", beat_period, exp_period);
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_valid(input int bound, output logic [31:0] val, output bit got);
    got = 1'b0;
    val = '0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clock);
      if (period_valid) begin
        got = 1'b1;
        val = beat_period;
      end
    end
  endtask

  task automatic wait_busy(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clock);
      if (busy) got = 1'b1;
    end
  endtask

  task automatic count_valids(input int k, output int cnt);
    cnt = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      if (period_valid) cnt++;
    end
  endtask

  task automatic press_key(input bit up, input bit dn, input int hold);
    tapup_n   = ~up;
    tapdown_n = ~dn;
    cycles(hold);
    tapup_n   = 1'b1;
    tapdown_n = 1'b1;
    cycles(hold);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [31:0] vals[2];
    bit          got;
    int          cnt;
    int          bounce[6] = '{1, 1, 2, 1, 1, 2};

    // reset values
    cycles(5);
    check("rst_bpm", bpm, 120);
    check("rst_hex100", hex100, 1);
    check("rst_hex10", hex10, 2);
    check("rst_hex0", hex0, 0);
    check("rst_period", beat_period, 25000000);
    check("rst_valid", period_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    cycles(10);

    // one clean up press, held: one step, one result
    exp_q.push_back(8'd130);
    tapup_n = 1'b0;
    wait_valid(100, v, got);
    check("up_seen", got, 1);
    check("up_period", v, 23076923);
    check("up_bpm", bpm, 130);
    check("up_hex10", hex10, 3);
    cycles(10);
    tapup_n = 1'b1;
    cycles(20);
    check("up_queue", exp_q.size(), 0);

    // short glitch is rejected
    tapdown_n = 1'b0;
    cycles(2);
    tapdown_n = 1'b1;
    cycles(20);
    check("glitch_bpm", bpm, 130);

    // bounce train then stable low: one step down
    for (int i = 0; i < 6; i++) begin
      tapdown_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(bounce[i]);
    end
    exp_q.push_back(8'd120);
    tapdown_n = 1'b0;
    wait_valid(100, v, got);
    check("bounce_seen", got, 1);
    check("bounce_period", v, 25000000);
    cycles(10);
    tapdown_n = 1'b1;
    cycles(20);
    check("bounce_queue", exp_q.size(), 0);

    // preset 5 lands 3 clocks after the switch moves
    exp_q.push_back(8'd110);
    sw_preset = 5'd5;
    cycles(2);
    check("sw5_early", bpm, 120);
    cycles(1);
    check("sw5_bpm", bpm, 110);
    wait_valid(60, v, got);
    check("sw5_seen", got, 1);
    check("sw5_period", v, 27272727);

    // preset 31 clamps to the upper limit
    exp_q.push_back(8'd230);
    sw_preset = 5'd31;
    cycles(3);
    check("sw31_bpm", bpm, 230);
    wait_valid(60, v, got);
    check("sw31_seen", got, 1);
    check("sw31_period", v, 13043478);

    // saturated up presses: no change, no new period
    press_key(1'b1, 1'b0, 10);
    press_key(1'b1, 1'b0, 10);
    count_valids(80, cnt);
    check("sat_hi_valids", cnt, 0);
    check("sat_hi_bpm", bpm, 230);

    // preset 0, then down saturates; simultaneous up+down is ignored
    exp_q.push_back(8'd60);
    sw_preset = 5'd0;
    wait_valid(60, v, got);
    check("sw0_seen", got, 1);
    check("sw0_period", v, 50000000);
    press_key(1'b0, 1'b1, 10);
    check("sat_lo_bpm", bpm, 60);
    press_key(1'b1, 1'b1, 10);
    count_valids(50, cnt);
    check("both_valids", cnt, 0);
    check("both_bpm", bpm, 60);

    // tempo change while a division runs: old result first, then the new one
    exp_q.push_back(8'd80);
    sw_preset = 5'd2;
    wait_busy(20, got);
    check("mid_busy", got, 1);
    cycles(4);
    exp_q.push_back(8'd90);
    tapup_n = 1'b0;
    cnt = 0;
    vals[0] = '0;
    vals[1] = '0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (period_valid) begin
        if (cnt < 2) vals[cnt] = beat_period;
        cnt++;
      end
    end
    tapup_n = 1'b1;
    check("mid_valids", cnt, 2);
    check("mid_first", vals[0], 37500000);
    check("mid_second", vals[1], 33333333);
    cycles(20);

    // reset in the middle of a division aborts it
    exp_q.push_back(8'd60);
    sw_preset = 5'd0;
    wait_busy(20, got);
    check("abort_busy", got, 1);
    cycles(20);
    reset = 1'b0;
    cycles(3);
    check("abort_bpm", bpm, 120);
    check("abort_period", beat_period, 25000000);
    check("abort_busy_low", busy, 0);
    check("abort_valid", period_valid, 0);
    reset = 1'b1;
    count_valids(80, cnt);
    check("abort_valids", cnt, 0);
    check("abort_bpm_after", bpm, 120);
    check("abort_queue", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
    $fatal(1);
  end

endmodule
